// File: rtl/data_mem_waitstate_if.sv
// CPU data-port bus: Avalon-style read/write/waitrequest handshake plus the
// responder's sticky protocol-fault flag.
interface data_mem_waitstate_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        fault;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest, fault
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest, fault
    );
endinterface

// File: rtl/data_mem_waitstate.sv
// Word-addressed data memory responder with a fixed number of wait states per
// transfer, per-byte write enables and a sticky bus-protocol fault flag.
module data_mem_waitstate #(
    parameter     INIT_FILE   = "",
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    data_mem_waitstate_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   fault_q, fault_d;
    logic                   cap_en;
    logic [31:0]            addr_q, wd_q;
    logic [3:0]             be_q;
    logic                   rd_q, wr_q;
    logic [31:0]            mem [DEPTH];

    logic                   req, bad, in_rng, changed, complete, waitreq, we;
    logic [ADDR_BITS-1:0]   idx;

    assign req     = bus.read | bus.write;
    assign bad     = (bus.read & bus.write) | (bus.address[1:0] != 2'b00);
    assign in_rng  = ((bus.address >> (ADDR_BITS + 2)) == 32'd0);
    assign idx     = bus.address[ADDR_BITS+1:2];
    assign changed = {bus.address, bus.read, bus.write, bus.byteenable, bus.writedata}
                  != {addr_q, rd_q, wr_q, be_q, wd_q};

    // Contents survive reset; cleared once at start-up.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        cap_en   = 1'b0;
        waitreq  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        waitreq = 1'b1;
                        cap_en  = 1'b1;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                waitreq = 1'b1;
                if (!req || changed) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                complete = req;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (req && bad) fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            if (cap_en) begin
                addr_q <= bus.address;
                wd_q   <= bus.writedata;
                be_q   <= bus.byteenable;
                rd_q   <= bus.read;
                wr_q   <= bus.write;
            end
        end
    end

    // Outputs are gated by reset so a request held through reset sees an idle bus.
    assign we              = reset_n & complete & bus.write & ~bad & in_rng;
    assign bus.waitrequest = reset_n & waitreq;
    assign bus.fault       = fault_q;
    assign bus.readdata    = (reset_n && complete && bus.read && !bad && in_rng) ? mem[idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
    end
endmodule
